// File: rtl/quad_gate_bist_seq.sv
// Self-test sequencer for a quad 2-input gate package: drives an 8-step A/B schedule and checks Y against FUNC.
// Latency: 8*(SETTLE+2) cycles for a clean run, (k+1)*(SETTLE+2) for an early stop at step k.
// Backpressure: none; START is honoured only in IDLE/DONE and ignored while BUSY.
module quad_gate_bist_seq #(
    parameter int SETTLE       = 2,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       START,
    input  logic [2:0] FUNC,
    output logic [3:0] A,
    output logic [3:0] B,
    input  logic [3:0] Y,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [2:0] FAIL_STEP,
    output logic [3:0] FAIL_MASK
);

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_DONE} state_t;

    state_t     state, state_nxt;
    logic [2:0] func_q;
    logic [2:0] step_q;
    logic [3:0] settle_q;
    logic [3:0] vec_a, vec_b, expect_y, mis;
    logic       start_ok, func_bad, stop_now;

    assign start_ok = START && ((state == S_IDLE) || (state == S_DONE));
    assign func_bad = (FUNC > 3'd4);

    // Steps 4..7 rotate the vector per gate so neighbours never share inputs.
    always_comb begin
        logic [1:0] v;
        vec_a = '0;
        vec_b = '0;
        v     = '0;
        for (int g = 0; g < 4; g++) begin
            v = step_q[2] ? (step_q[1:0] + 2'(g)) : step_q[1:0];
            vec_a[g] = v[1];
            vec_b[g] = v[0];
        end
    end

    always_comb begin
        expect_y = '0;
        case (func_q)
            3'd0:    expect_y = A | B;
            3'd1:    expect_y = A & B;
            3'd2:    expect_y = ~(A & B);
            3'd3:    expect_y = ~(A | B);
            3'd4:    expect_y = A ^ B;
            default: expect_y = '0;
        endcase
        mis      = Y ^ expect_y;
        stop_now = ((|mis) && STOP_ON_FAIL) || (step_q == 3'd7);
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (START) state_nxt = func_bad ? S_DONE : S_APPLY;
            S_APPLY:        state_nxt = S_WAIT;
            S_WAIT:         if (settle_q <= 4'd1) state_nxt = S_CHECK;
            S_CHECK:        state_nxt = stop_now ? S_DONE : S_APPLY;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state == S_APPLY) || (state == S_WAIT) || (state == S_CHECK);
        DONE = (state == S_DONE);
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            func_q    <= '0;
            step_q    <= '0;
            settle_q  <= '0;
            A         <= '0;
            B         <= '0;
            PASS      <= 1'b0;
            FAIL_STEP <= '0;
            FAIL_MASK <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        func_q    <= FUNC;
                        step_q    <= '0;
                        A         <= '0;
                        B         <= '0;
                        PASS      <= 1'b0;
                        FAIL_STEP <= '0;
                        FAIL_MASK <= func_bad ? 4'hF : 4'h0;
                    end
                end
                S_APPLY: begin
                    A        <= vec_a;
                    B        <= vec_b;
                    settle_q <= SETTLE_L;
                end
                S_WAIT: settle_q <= settle_q - 4'd1;
                S_CHECK: begin
                    if (|mis) begin
                        FAIL_MASK <= FAIL_MASK | mis;
                        if (FAIL_MASK == 4'h0) FAIL_STEP <= step_q;
                    end
                    if (stop_now) begin
                        A    <= '0;
                        B    <= '0;
                        PASS <= ((FAIL_MASK | mis) == 4'h0);
                    end else begin
                        step_q <= step_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/quad_gate_bist_seq.md
Name: quad_gate_bist_seq

Overview:
Built-in self-test sequencer for one quad 2-input gate package (74x00/08/32/02/86 class). It drives all four gates' A/B inputs through an 8-step vector schedule, waits a settle interval, and compares Y against the selected gate function. It reports pass/fail, the first failing step and a per-gate failure mask. It sits beside a gate-package instance in board-level benches and self-check harnesses.

Parameters:
SETTLE, 2, settle cycles per step between driving A/B and sampling Y; legal range 1..15.
STOP_ON_FAIL, 1, 1 = finish at the first failing step; 0 = run all 8 steps and accumulate the mask.

Ports:
CLK  in  1  clock; all state changes on the rising edge.
RST_n  in  1  asynchronous active-low reset.
START  in  1  begin a test; sampled only in IDLE and DONE.
FUNC  in  3  gate function, latched at START: 0 OR, 1 AND, 2 NAND, 3 NOR, 4 XOR; 5..7 illegal.
A  out  4  gate A inputs; bit 0 = gate 1 ... bit 3 = gate 4.
B  out  4  gate B inputs, same bit mapping.
Y  in  4  gate outputs from the device under test, same bit mapping.
BUSY  out  1  high while a test runs.
DONE  out  1  high from test completion until the next accepted START or reset.
PASS  out  1  valid while DONE: 1 = no mismatch.
FAIL_STEP  out  3  first failing step index; valid while DONE and PASS=0.
FAIL_MASK  out  4  gates that mismatched.

Behaviour:
- Reset (async, RST_n=0): state IDLE; A, B, FAIL_STEP and FAIL_MASK = 0; BUSY, DONE and PASS = 0; step and settle counters = 0.
- States: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE/DONE with START=1: latch FUNC, clear step, FAIL_MASK, FAIL_STEP, PASS and DONE, set BUSY, go to APPLY.
  - If the latched FUNC is 5..7, go directly to DONE instead: PASS=0, FAIL_STEP=0, FAIL_MASK=4'hF, no vectors driven.
- START while BUSY is ignored.
- APPLY (1 cycle): register A/B for the current step, load the settle counter with SETTLE, go to WAIT.
- WAIT (SETTLE cycles): decrement; on reaching zero go to CHECK.
- CHECK (1 cycle): compute the expected value per gate and compare with Y.
  - Mismatch: OR the failing bits into FAIL_MASK. If this is the first failure, FAIL_STEP = step.
  - Then go to DONE if (mismatch and STOP_ON_FAIL) or step==7; otherwise step+1 and go to APPLY.
- Vector schedule: step s (0..7), gate g (0..3). Vector index v = s for s<4; v = (s-4+g) mod 4 for s>=4. A[g] = v[1], B[g] = v[0].
  - Steps 0..3 apply the uniform truth table to all gates.
  - Steps 4..7 stagger the vectors so adjacent gates see different inputs, which exposes output bridges.
- Entering DONE: BUSY=0, DONE=1, A and B = 0, PASS = (FAIL_MASK==0). Outputs hold until START or reset.
- Timing: with START sampled at edge 0, BUSY=1 after edge 0. A clean run raises DONE after edge 8*(SETTLE+2); with SETTLE=2 that is edge 32.
- An early stop at step k raises DONE after edge (k+1)*(SETTLE+2).
- Y is sampled only in CHECK; Y activity in other states has no effect.
- Reset mid-run aborts immediately to the reset values; no partial result is retained.

Test Plan:
- Good OR model, FUNC=0, SETTLE=2 -> BUSY 1..32, DONE=1 at edge 32, PASS=1, FAIL_MASK=0000.
- OR model with Y[2] stuck at 0, STOP_ON_FAIL=1 -> fails at step 1 (A=0, B=1, expected 1); DONE at edge 8; FAIL_STEP=1, FAIL_MASK=0100, PASS=0.
- OR model with Y[0] and Y[1] bridged (both = Y0|Y1), STOP_ON_FAIL=0 -> steps 0..3 pass; step 4 fails gate 0, step 7 fails gate 1. Result: FAIL_STEP=4, FAIL_MASK=0011, DONE at edge 32.
- Good NAND model, FUNC=2 -> PASS=1. The same model run with FUNC=0 -> mismatch at step 0, FAIL_STEP=0, FAIL_MASK=1111.
- FUNC=6 with START -> DONE one edge later, PASS=0, FAIL_MASK=1111, A=B=0 throughout.
- START pulsed at edge 10 of a run -> ignored, run completes normally. RST_n low at edge 15 -> all outputs return to reset values immediately. A new START then runs to PASS.
